// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: one-hot vector widths, bit positions and the
// RV64I major opcodes. The execute stage imports this same package.
package decode_stage_pkg;

    localparam int OP_WIDTH     = 11;
    localparam int ALU_WIDTH    = 10;
    localparam int BRANCH_WIDTH = 6;

    localparam int op_lui    = 0;
    localparam int op_auipc  = 1;
    localparam int op_jal    = 2;
    localparam int op_jalr   = 3;
    localparam int op_branch = 4;
    localparam int op_load   = 5;
    localparam int op_store  = 6;
    localparam int op_alui   = 7;
    localparam int op_aluiw  = 8;
    localparam int op_alur   = 9;
    localparam int op_alurw  = 10;

    localparam int alu_add  = 0;
    localparam int alu_sub  = 1;
    localparam int alu_sll  = 2;
    localparam int alu_slt  = 3;
    localparam int alu_sltu = 4;
    localparam int alu_xor  = 5;
    localparam int alu_srl  = 6;
    localparam int alu_sra  = 7;
    localparam int alu_or   = 8;
    localparam int alu_and  = 9;

    localparam int branch_eq  = 0;
    localparam int branch_ne  = 1;
    localparam int branch_lt  = 2;
    localparam int branch_ge  = 3;
    localparam int branch_ltu = 4;
    localparam int branch_geu = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_ALUI   = 7'b0010011;
    localparam logic [6:0] OPC_ALUIW  = 7'b0011011;
    localparam logic [6:0] OPC_ALUR   = 7'b0110011;
    localparam logic [6:0] OPC_ALURW  = 7'b0111011;

    // Which bit layout the immediate is gathered from
    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

endpackage

// File: rtl/decode_stage_decode_logic.sv
// Purely combinational instruction decoder: opcode class, ALU op, branch
// condition, sign-extended immediate, destination register and illegal flag.
module decode_logic
    import decode_stage_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]             inst,
    output logic [OP_WIDTH-1:0]     epcode,
    output logic [ALU_WIDTH-1:0]    alu_op,
    output logic [BRANCH_WIDTH-1:0] branch_op,
    output logic [XLEN-1:0]         imme,
    output logic [4:0]              rd,
    output logic                    illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       opcode_bad;
    logic       branch_bad;
    imm_fmt_e   imm_fmt;

    assign opcode  = inst[6:0];
    assign funct3  = inst[14:12];
    assign rd      = inst[11:7];
    assign illegal = opcode_bad | branch_bad;

    // Classify the major opcode and pick the immediate layout it uses
    always_comb begin
        epcode     = '0;
        opcode_bad = 1'b0;
        imm_fmt    = IMM_NONE;
        case (opcode)
            OPC_LUI:    begin epcode[op_lui]    = 1'b1; imm_fmt = IMM_U; end
            OPC_AUIPC:  begin epcode[op_auipc]  = 1'b1; imm_fmt = IMM_U; end
            OPC_JAL:    begin epcode[op_jal]    = 1'b1; imm_fmt = IMM_J; end
            OPC_JALR:   begin epcode[op_jalr]   = 1'b1; imm_fmt = IMM_I; end
            OPC_BRANCH: begin epcode[op_branch] = 1'b1; imm_fmt = IMM_B; end
            OPC_LOAD:   begin epcode[op_load]   = 1'b1; imm_fmt = IMM_I; end
            OPC_STORE:  begin epcode[op_store]  = 1'b1; imm_fmt = IMM_S; end
            OPC_ALUI:   begin epcode[op_alui]   = 1'b1; imm_fmt = IMM_I; end
            OPC_ALUIW:  begin epcode[op_aluiw]  = 1'b1; imm_fmt = IMM_I; end
            OPC_ALUR:   begin epcode[op_alur]   = 1'b1; end
            OPC_ALURW:  begin epcode[op_alurw]  = 1'b1; end
            default:    opcode_bad = 1'b1;
        endcase
    end

    // ALU operation from funct3; inst[30] selects sub (register forms only) and sra
    always_comb begin
        alu_op = '0;
        if (epcode[op_alur] | epcode[op_alurw] | epcode[op_alui] | epcode[op_aluiw]) begin
            case (funct3)
                3'b000: begin
                    if ((epcode[op_alur] | epcode[op_alurw]) & inst[30]) alu_op[alu_sub] = 1'b1;
                    else                                                 alu_op[alu_add] = 1'b1;
                end
                3'b001: alu_op[alu_sll]  = 1'b1;
                3'b010: alu_op[alu_slt]  = 1'b1;
                3'b011: alu_op[alu_sltu] = 1'b1;
                3'b100: alu_op[alu_xor]  = 1'b1;
                3'b101: begin
                    if (inst[30]) alu_op[alu_sra] = 1'b1;
                    else          alu_op[alu_srl] = 1'b1;
                end
                3'b110: alu_op[alu_or]   = 1'b1;
                default: alu_op[alu_and] = 1'b1;
            endcase
        end
    end

    // Branch condition from funct3; the two unused encodings are illegal
    always_comb begin
        branch_op  = '0;
        branch_bad = 1'b0;
        if (epcode[op_branch]) begin
            case (funct3)
                3'b000:  branch_op[branch_eq]  = 1'b1;
                3'b001:  branch_op[branch_ne]  = 1'b1;
                3'b100:  branch_op[branch_lt]  = 1'b1;
                3'b101:  branch_op[branch_ge]  = 1'b1;
                3'b110:  branch_op[branch_ltu] = 1'b1;
                3'b111:  branch_op[branch_geu] = 1'b1;
                default: branch_bad = 1'b1;
            endcase
        end
    end

    // Gather and sign-extend the immediate from inst[31]
    always_comb begin
        imme = '0;
        case (imm_fmt)
            IMM_I: imme = {{(XLEN-12){inst[31]}}, inst[31:20]};
            IMM_S: imme = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: imme = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U: imme = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};
            IMM_J: imme = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imme = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decodes the fetched instruction, reads the register file and
// holds the result in a two-entry skid buffer driving the execute operand bus.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int XLEN     = 64,
    parameter int PC_WIDTH = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    F_valid_i,
    output logic                    F_ready_o,
    input  logic [31:0]             F_inst_i,
    input  logic [PC_WIDTH-1:0]     F_PC_i,
    output logic [4:0]              rf_rs1_addr_o,
    output logic [4:0]              rf_rs2_addr_o,
    input  logic [XLEN-1:0]         rf_rs1_data_i,
    input  logic [XLEN-1:0]         rf_rs2_data_i,
    output logic                    DD_valid_o,
    input  logic                    DD_ready_i,
    output logic [XLEN-1:0]         DD_rs1_data_o,
    output logic [XLEN-1:0]         DD_rs2_data_o,
    output logic [OP_WIDTH-1:0]     DD_epcode_o,
    output logic [ALU_WIDTH-1:0]    DD_ALU_op_o,
    output logic [BRANCH_WIDTH-1:0] DD_branch_op_o,
    output logic [XLEN-1:0]         DD_imme_o,
    output logic [PC_WIDTH-1:0]     DD_PC_o,
    output logic [4:0]              DD_rd_o,
    output logic                    DD_illegal_o
);

    typedef struct packed {
        logic [XLEN-1:0]         rs1_data;
        logic [XLEN-1:0]         rs2_data;
        logic [OP_WIDTH-1:0]     epcode;
        logic [ALU_WIDTH-1:0]    alu_op;
        logic [BRANCH_WIDTH-1:0] branch_op;
        logic [XLEN-1:0]         imme;
        logic [PC_WIDTH-1:0]     pc;
        logic [4:0]              rd;
        logic                    illegal;
    } payload_t;

    logic [OP_WIDTH-1:0]     dec_epcode;
    logic [ALU_WIDTH-1:0]    dec_alu_op;
    logic [BRANCH_WIDTH-1:0] dec_branch_op;
    logic [XLEN-1:0]         dec_imme;
    logic [4:0]              dec_rd;
    logic                    dec_illegal;

    payload_t in_payload;
    payload_t main_q;
    payload_t skid_q;
    logic     main_valid;
    logic     skid_valid;
    logic     ready_q;
    logic     main_valid_d;
    logic     skid_valid_d;
    logic     load_main_in;
    logic     load_main_skid;
    logic     load_skid;
    logic     accept;

    decode_logic #(.XLEN(XLEN)) u_decode_logic (
        .inst      (F_inst_i),
        .epcode    (dec_epcode),
        .alu_op    (dec_alu_op),
        .branch_op (dec_branch_op),
        .imme      (dec_imme),
        .rd        (dec_rd),
        .illegal   (dec_illegal)
    );

    assign rf_rs1_addr_o = F_inst_i[19:15];
    assign rf_rs2_addr_o = F_inst_i[24:20];
    assign accept        = F_valid_i & ready_q;

    // Bundle the decoded fields with the register reads and PC for capture
    always_comb begin
        in_payload           = '0;
        in_payload.rs1_data  = rf_rs1_data_i;
        in_payload.rs2_data  = rf_rs2_data_i;
        in_payload.epcode    = dec_epcode;
        in_payload.alu_op    = dec_alu_op;
        in_payload.branch_op = dec_branch_op;
        in_payload.imme      = dec_imme;
        in_payload.pc        = F_PC_i;
        in_payload.rd        = dec_rd;
        in_payload.illegal   = dec_illegal;
    end

    // Skid buffer steering: flush drops everything, a free or draining main slot
    // takes the skid entry first (if any) else the new instruction, and a stalled
    // main slot pushes a new instruction into skid
    always_comb begin
        main_valid_d   = main_valid;
        skid_valid_d   = skid_valid;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid || DD_ready_i) begin
            if (skid_valid) begin
                load_main_skid = 1'b1;
                main_valid_d   = 1'b1;
                skid_valid_d   = 1'b0;
            end else if (accept) begin
                load_main_in = 1'b1;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            load_skid    = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    // Entry state and payload registers; payload only moves on a load so the
    // bus stays stable while execute stalls
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            main_valid <= main_valid_d;
            skid_valid <= skid_valid_d;
            ready_q    <= ~skid_valid_d;
            if (load_main_in)        main_q <= in_payload;
            else if (load_main_skid) main_q <= skid_q;
            if (load_skid)           skid_q <= in_payload;
        end
    end

    assign F_ready_o      = ready_q;
    assign DD_valid_o     = main_valid;
    assign DD_rs1_data_o  = main_q.rs1_data;
    assign DD_rs2_data_o  = main_q.rs2_data;
    assign DD_epcode_o    = main_q.epcode;
    assign DD_ALU_op_o    = main_q.alu_op;
    assign DD_branch_op_o = main_q.branch_op;
    assign DD_imme_o      = main_q.imme;
    assign DD_PC_o        = main_q.pc;
    assign DD_rd_o        = main_q.rd;
    assign DD_illegal_o   = main_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed test-plan cases followed by
// randomized traffic compared against a queue-based reference model.
module tb_decode_stage;
    import decode_stage_pkg::*;

    logic                    clk_i = 1'b0;
    logic                    rst_i = 1'b0;
    logic                    flush_i = 1'b0;
    logic                    F_valid_i = 1'b0;
    logic                    F_ready_o;
    logic [31:0]             F_inst_i = '0;
    logic [63:0]             F_PC_i = '0;
    logic [4:0]              rf_rs1_addr_o;
    logic [4:0]              rf_rs2_addr_o;
    logic [63:0]             rf_rs1_data_i;
    logic [63:0]             rf_rs2_data_i;
    logic                    DD_valid_o;
    logic                    DD_ready_i = 1'b0;
    logic [63:0]             DD_rs1_data_o;
    logic [63:0]             DD_rs2_data_o;
    logic [OP_WIDTH-1:0]     DD_epcode_o;
    logic [ALU_WIDTH-1:0]    DD_ALU_op_o;
    logic [BRANCH_WIDTH-1:0] DD_branch_op_o;
    logic [63:0]             DD_imme_o;
    logic [63:0]             DD_PC_o;
    logic [4:0]              DD_rd_o;
    logic                    DD_illegal_o;

    typedef struct packed {
        logic [63:0]             rs1;
        logic [63:0]             rs2;
        logic [63:0]             imm;
        logic [63:0]             pc;
        logic [OP_WIDTH-1:0]     op;
        logic [ALU_WIDTH-1:0]    alu;
        logic [BRANCH_WIDTH-1:0] br;
        logic [4:0]              rd;
        logic                    ill;
    } exp_t;

    logic [63:0] regs [32];
    exp_t        model_q [$];
    int          vector_count = 0;
    int          miscompare_count = 0;

    always #5 clk_i = ~clk_i;

    assign rf_rs1_data_i = regs[rf_rs1_addr_o];
    assign rf_rs2_data_i = regs[rf_rs2_addr_o];

    decode_stage #(.XLEN(64), .PC_WIDTH(64)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_i        (flush_i),
        .F_valid_i      (F_valid_i),
        .F_ready_o      (F_ready_o),
        .F_inst_i       (F_inst_i),
        .F_PC_i         (F_PC_i),
        .rf_rs1_addr_o  (rf_rs1_addr_o),
        .rf_rs2_addr_o  (rf_rs2_addr_o),
        .rf_rs1_data_i  (rf_rs1_data_i),
        .rf_rs2_data_i  (rf_rs2_data_i),
        .DD_valid_o     (DD_valid_o),
        .DD_ready_i     (DD_ready_i),
        .DD_rs1_data_o  (DD_rs1_data_o),
        .DD_rs2_data_o  (DD_rs2_data_o),
        .DD_epcode_o    (DD_epcode_o),
        .DD_ALU_op_o    (DD_ALU_op_o),
        .DD_branch_op_o (DD_branch_op_o),
        .DD_imme_o      (DD_imme_o),
        .DD_PC_o        (DD_PC_o),
        .DD_rd_o        (DD_rd_o),
        .DD_illegal_o   (DD_illegal_o)
    );

    // Count one comparison and report it if observed differs from expected
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miscompare_count++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference decode from the instruction rules using signed integer arithmetic
    function automatic exp_t refDecode(input logic [31:0] inst, input logic [63:0] pc);
        exp_t       e;
        int         si;
        longint     sx;
        int         cls;
        logic [2:0] f3;
        bit         is_reg;
        e     = '0;
        e.pc  = pc;
        e.rd  = inst[11:7];
        e.rs1 = regs[inst[19:15]];
        e.rs2 = regs[inst[24:20]];
        si    = inst;
        sx    = si;
        f3    = inst[14:12];
        cls   = -1;
        case (inst[6:0])
            7'b0110111: cls = op_lui;
            7'b0010111: cls = op_auipc;
            7'b1101111: cls = op_jal;
            7'b1100111: cls = op_jalr;
            7'b1100011: cls = op_branch;
            7'b0000011: cls = op_load;
            7'b0100011: cls = op_store;
            7'b0010011: cls = op_alui;
            7'b0011011: cls = op_aluiw;
            7'b0110011: cls = op_alur;
            7'b0111011: cls = op_alurw;
            default:    cls = -1;
        endcase
        if (cls < 0) begin
            e.ill = 1'b1;
            return e;
        end
        e.op[cls] = 1'b1;
        is_reg = (cls == op_alur) || (cls == op_alurw);
        if (is_reg || cls == op_alui || cls == op_aluiw) begin
            case (f3)
                3'd0: e.alu[(is_reg && inst[30]) ? alu_sub : alu_add] = 1'b1;
                3'd1: e.alu[alu_sll]  = 1'b1;
                3'd2: e.alu[alu_slt]  = 1'b1;
                3'd3: e.alu[alu_sltu] = 1'b1;
                3'd4: e.alu[alu_xor]  = 1'b1;
                3'd5: e.alu[inst[30] ? alu_sra : alu_srl] = 1'b1;
                3'd6: e.alu[alu_or]   = 1'b1;
                default: e.alu[alu_and] = 1'b1;
            endcase
        end
        if (cls == op_branch) begin
            case (f3)
                3'd0: e.br[branch_eq]  = 1'b1;
                3'd1: e.br[branch_ne]  = 1'b1;
                3'd4: e.br[branch_lt]  = 1'b1;
                3'd5: e.br[branch_ge]  = 1'b1;
                3'd6: e.br[branch_ltu] = 1'b1;
                3'd7: e.br[branch_geu] = 1'b1;
                default: e.ill = 1'b1;
            endcase
        end
        if (cls == op_jalr || cls == op_load || cls == op_alui || cls == op_aluiw)
            e.imm = sx >>> 20;
        else if (cls == op_store)
            e.imm = ((sx >>> 25) <<< 5) | longint'(inst[11:7]);
        else if (cls == op_branch)
            e.imm = ((sx >>> 31) <<< 12) | (longint'(inst[7]) << 11)
                  | (longint'(inst[30:25]) << 5) | (longint'(inst[11:8]) << 1);
        else if (cls == op_lui || cls == op_auipc)
            e.imm = sx & -64'sd4096;
        else if (cls == op_jal)
            e.imm = ((sx >>> 31) <<< 20) | (longint'(inst[19:12]) << 12)
                  | (longint'(inst[20]) << 11) | (longint'(inst[30:21]) << 1);
        return e;
    endfunction

    // Drive one cycle of inputs, advance the model, then check state at the negedge
    task automatic applyStimulus(input logic v, input logic [31:0] inst, input logic [63:0] pc,
                                 input logic rdy, input logic fl, input logic rs);
        bit acc;
        bit drn;
        F_valid_i  = v;
        F_inst_i   = inst;
        F_PC_i     = pc;
        DD_ready_i = rdy;
        flush_i    = fl;
        rst_i      = rs;
        #1;
        if (!rs) checkOutput("rs1_addr", 64'(rf_rs1_addr_o), 64'(inst[19:15]));
        if (rs || fl) begin
            model_q.delete();
        end else begin
            acc = v && (model_q.size() < 2);
            drn = (model_q.size() > 0) && rdy;
            if (drn) void'(model_q.pop_front());
            if (acc) model_q.push_back(refDecode(inst, pc));
        end
        @(posedge clk_i);
        @(negedge clk_i);
        checkOutput("dd_valid", 64'(DD_valid_o), 64'(model_q.size() > 0));
        checkOutput("f_ready", 64'(F_ready_o), 64'(model_q.size() < 2));
        if (model_q.size() > 0) begin
            checkOutput("rs1_data", DD_rs1_data_o, model_q[0].rs1);
            checkOutput("rs2_data", DD_rs2_data_o, model_q[0].rs2);
            checkOutput("imme", DD_imme_o, model_q[0].imm);
            checkOutput("pc", DD_PC_o, model_q[0].pc);
            checkOutput("epcode", 64'(DD_epcode_o), 64'(model_q[0].op));
            checkOutput("alu_op", 64'(DD_ALU_op_o), 64'(model_q[0].alu));
            checkOutput("branch_op", 64'(DD_branch_op_o), 64'(model_q[0].br));
            checkOutput("rd", 64'(DD_rd_o), 64'(model_q[0].rd));
            checkOutput("illegal", 64'(DD_illegal_o), 64'(model_q[0].ill));
        end
    endtask

    initial begin
        logic [6:0]  opcs [12];
        logic [31:0] r;
        logic [31:0] cur_inst;
        logic [63:0] cur_pc;
        bit          pending;
        bit          v;
        bit          rdy;
        bit          fl;
        bit          rs;
        int          pick;

        opcs = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
                 7'b0100011, 7'b0010011, 7'b0011011, 7'b0110011, 7'b0111011, 7'b1111111};
        for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
        regs[0] = '0;
        regs[1] = 64'd5;
        regs[2] = 64'd7;

        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1);
        checkOutput("reset_valid", 64'(DD_valid_o), 64'd0);
        checkOutput("reset_ready", 64'(F_ready_o), 64'd1);
        checkOutput("reset_imme", DD_imme_o, 64'd0);
        checkOutput("reset_epcode", 64'(DD_epcode_o), 64'd0);
        checkOutput("reset_pc", DD_PC_o, 64'd0);
        checkOutput("reset_illegal", 64'(DD_illegal_o), 64'd0);

        applyStimulus(1'b1, 32'h002081B3, 64'h1000, 1'b1, 1'b0, 1'b0);
        checkOutput("add_valid", 64'(DD_valid_o), 64'd1);
        checkOutput("add_epcode", 64'(DD_epcode_o), 64'(1) << op_alur);
        checkOutput("add_alu", 64'(DD_ALU_op_o), 64'(1) << alu_add);
        checkOutput("add_rs1", DD_rs1_data_o, 64'd5);
        checkOutput("add_rs2", DD_rs2_data_o, 64'd7);
        checkOutput("add_rd", 64'(DD_rd_o), 64'd3);
        checkOutput("add_imme", DD_imme_o, 64'd0);

        applyStimulus(1'b1, 32'hFFF00093, 64'h1004, 1'b1, 1'b0, 1'b0);
        checkOutput("addi_epcode", 64'(DD_epcode_o), 64'(1) << op_alui);
        checkOutput("addi_alu", 64'(DD_ALU_op_o), 64'(1) << alu_add);
        checkOutput("addi_imme", DD_imme_o, 64'hFFFF_FFFF_FFFF_FFFF);

        applyStimulus(1'b1, 32'h4030D093, 64'h1008, 1'b1, 1'b0, 1'b0);
        checkOutput("srai_alu", 64'(DD_ALU_op_o), 64'(1) << alu_sra);

        applyStimulus(1'b1, 32'hFE208CE3, 64'h100C, 1'b1, 1'b0, 1'b0);
        checkOutput("beq_epcode", 64'(DD_epcode_o), 64'(1) << op_branch);
        checkOutput("beq_branch", 64'(DD_branch_op_o), 64'(1) << branch_eq);
        checkOutput("beq_imme", DD_imme_o, 64'hFFFF_FFFF_FFFF_FFF8);

        applyStimulus(1'b1, 32'h0000007F, 64'h1010, 1'b1, 1'b0, 1'b0);
        checkOutput("bad_illegal", 64'(DD_illegal_o), 64'd1);
        checkOutput("bad_epcode", 64'(DD_epcode_o), 64'd0);

        applyStimulus(1'b1, 32'h800002B7, 64'h1014, 1'b1, 1'b0, 1'b0);
        checkOutput("lui_imme", DD_imme_o, 64'hFFFF_FFFF_8000_0000);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);

        // Back-pressure: A to main, B to skid, C held by fetch until release
        applyStimulus(1'b1, 32'h002081B3, 64'h2000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hFFF00093, 64'h2004, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_ready_low", 64'(F_ready_o), 64'd0);
        applyStimulus(1'b1, 32'h4030D093, 64'h2008, 1'b0, 1'b0, 1'b0);
        checkOutput("bp_hold_a", DD_PC_o, 64'h2000);
        applyStimulus(1'b1, 32'h4030D093, 64'h2008, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_order_b", DD_PC_o, 64'h2004);
        applyStimulus(1'b1, 32'h4030D093, 64'h2008, 1'b1, 1'b0, 1'b0);
        checkOutput("bp_order_c", DD_PC_o, 64'h2008);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);

        // Flush with both entries full and a fresh offer in the same cycle
        applyStimulus(1'b1, 32'h002081B3, 64'h3000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'hFFF00093, 64'h3004, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 32'h4030D093, 64'h3008, 1'b0, 1'b1, 1'b0);
        checkOutput("flush_valid", 64'(DD_valid_o), 64'd0);
        checkOutput("flush_ready", 64'(F_ready_o), 64'd1);
        applyStimulus(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("flush_empty", 64'(DD_valid_o), 64'd0);

        // Randomized traffic; fetch keeps an unaccepted offer stable
        pending  = 1'b0;
        cur_inst = '0;
        cur_pc   = 64'h8000;
        for (int n = 0; n < 3000; n++) begin
            v   = pending || ($urandom_range(0, 9) < 7);
            rdy = $urandom_range(0, 9) < 6;
            fl  = $urandom_range(0, 99) < 3;
            rs  = $urandom_range(0, 199) < 2;
            if (!pending) begin
                pick = $urandom_range(0, 11);
                r    = $urandom;
                cur_inst = {r[31:7], (pick == 11) ? 7'($urandom) : opcs[pick]};
                cur_pc   = cur_pc + 64'd4;
            end
            pending = v && (model_q.size() >= 2) && !fl && !rs;
            applyStimulus(v, cur_inst, cur_pc, rdy, fl, rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miscompare_count);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the in-order RISC-V (RV64I) pipeline. Accepts a fetched instruction and PC from fetch, decodes it into the one-hot opcode, ALU-op and branch-op vectors plus the sign-extended immediate, and reads the register file. It holds the result in a two-entry skid buffer that drives the DD_* operand bus of the execute stage. All handshakes use valid/ready, with a flush from branch resolution.

## Interface
Parameters:
- XLEN, 64, datapath width; immediates sign-extend to XLEN.
- PC_WIDTH, 64, PC width.

Ports:
- clk_i, in, 1, clock.
- rst_i, in, 1, reset; synchronous, active-high.
- flush_i, in, 1, discard all held and incoming instructions.
- F_valid_i, in, 1, fetch offers an instruction.
- F_ready_o, out, 1, stage can accept.
- F_inst_i, in, 32, instruction word.
- F_PC_i, in, PC_WIDTH, instruction PC.
- rf_rs1_addr_o, out, 5, inst[19:15], combinational from F_inst_i.
- rf_rs2_addr_o, out, 5, inst[24:20], combinational from F_inst_i.
- rf_rs1_data_i, in, XLEN, asynchronous read data; x0 reads 0.
- rf_rs2_data_i, in, XLEN, asynchronous read data.
- DD_valid_o, out, 1, execute bus valid.
- DD_ready_i, in, 1, execute accepts.
- DD_rs1_data_o, out, XLEN, rs1 operand.
- DD_rs2_data_o, out, XLEN, rs2 operand.
- DD_epcode_o, out, OP_WIDTH (11), one-hot opcode class.
- DD_ALU_op_o, out, ALU_WIDTH (10), one-hot ALU op.
- DD_branch_op_o, out, BRANCH_WIDTH (6), one-hot branch condition.
- DD_imme_o, out, XLEN, immediate.
- DD_PC_o, out, PC_WIDTH, PC.
- DD_rd_o, out, 5, inst[11:7].
- DD_illegal_o, out, 1, unrecognised opcode.

## Operation
- Opcode (inst[6:0]) maps to epcode bits as follows:
  - 0110111 → lui; 0010111 → auipc; 1101111 → jal; 1100111 → jalr.
  - 1100011 → branch; 0000011 → load; 0100011 → store.
  - 0010011 → alui; 0011011 → aluiw; 0110011 → alur; 0111011 → alurw.
  - Any other opcode: epcode = 0 and illegal = 1.
- ALU op is set only for alur, alurw, alui and aluiw. Decode from funct3:
  - 000: add; sub only for alur/alurw when inst[30] = 1.
  - 001: sll; 010: slt; 011: sltu; 100: xor.
  - 101: sra if inst[30] = 1, else srl.
  - 110: or; 111: and.
  - For all other classes ALU_op = 0.
- Branch op is set only for branch. Decode from funct3:
  - 000 eq, 001 ne, 100 lt, 101 ge, 110 ltu, 111 geu.
  - Branch funct3 010 or 011 → illegal = 1, branch_op = 0.
- Immediate formats, each sign-extended from inst[31]:
  - I-type for jalr, load, alui, aluiw.
  - S-type for store.
  - B-type for branch (bit 0 = 0).
  - U-type for lui and auipc: {inst[31:12], 12'b0}.
  - J-type for jal.
  - All other classes: 0.
- Decode and register read are combinational on the incoming instruction. Everything is captured at acceptance (F_valid_i & F_ready_o).
- RAW hazard stalling is not this block's job. Upstream holds F_valid_i low until its sources are written back.
- Skid buffer entries:
  - main: drives DD_*.
  - skid: holds one overflow entry.
- F_ready_o = ~skid_valid, driven from a register.
- Buffer transitions:
  - Accept while main is empty or being drained (DD_ready_i high) → data goes to main.
  - Accept while main is held (DD_valid_o & ~DD_ready_i) → data goes to skid.
  - Main drained while skid is valid → skid moves to main; skid empties.
- Flush behaviour:
  - Next edge clears main_valid and skid_valid.
  - An instruction offered in the same cycle is dropped.
  - Flush has priority over accept and drain.

## Timing
- Latency: 1 cycle from acceptance to DD_valid_o.
- Throughput: 1 per cycle while DD_ready_i = 1.
- Reset state after the first rising edge with rst_i = 1:
  - DD_valid_o = 0.
  - F_ready_o = 1.
  - All DD_* payload = 0; DD_illegal_o = 0.
- Payload registers update only on load, so DD_* holds stable while DD_valid_o & ~DD_ready_i.
- rst_i mid-stream discards both entries and behaves exactly as reset. rst_i has priority over flush_i.
- Simultaneous accept and drain with skid empty: main is replaced and DD_valid_o stays 1 with no bubble.
- Simultaneous accept and drain with skid full: cannot occur, because F_ready_o = 0.

## Structure
- Shared package/header (define.v) contains:
  - OP_WIDTH, ALU_WIDTH, BRANCH_WIDTH.
  - One-hot bit indices op_*, alu_*, branch_*.
  - The 7-bit RISC-V opcode constants.
- The execute stage uses the same package, so no widths are duplicated.
- Sub-module decode_logic: purely combinational inst → {epcode, ALU_op, branch_op, imme, rd, illegal}. The top holds the skid buffer and handshake.

## Test plan
- Reset, then `add x3,x1,x2` (0x002081B3) with rs1 = 5, rs2 = 7 and DD_ready_i = 1 → next cycle:
  - DD_valid_o = 1; epcode = alur; ALU_op = add.
  - rs1 = 5, rs2 = 7, rd = 3, imme = 0.
- `addi x1,x0,-1` (0xFFF00093) → alui, add, imme = 0xFFFF_FFFF_FFFF_FFFF.
- `srai x1,x1,3` (0x4030D093) → ALU_op = sra.
- `beq x1,x2,-8` (0xFE208CE3) → branch, branch_eq, imme = -8.
- Back-pressure: DD_ready_i = 0 while three instructions are offered back to back:
  - Second lands in skid; F_ready_o = 0 next cycle; third is held by fetch.
  - Release DD_ready_i → outputs arrive in order with no loss.
- Flush with both entries full and a valid offer in the same cycle → next cycle DD_valid_o = 0, F_ready_o = 1; nothing from the old stream appears.
- Opcode 0x7F → DD_illegal_o = 1, epcode = 0.
- `lui x5,0x80000` (0x800002B7) → imme = 0xFFFF_FFFF_8000_0000.
